r2w_sync_full: RTL
==================

// Module: r2w_sync_full
// PURPOSE
//  Write-domain half of the async FIFO, next generation of the r2w pointer synchroniser.
//  - Brings the read-domain Gray pointer into wclk through a parametrised N-flop chain.
//  - Owns the write pointer (binary + Gray) and produces full, almost-full, fill level
//    and overflow status.
//  - Flags illegal Gray transitions (more than one bit changing) on the synchronised pointer.
//  Sits between the write port / memory write address and the read-side pointer logic.
// PARAMETERS
//  ADDRSIZE      4   memory address bits; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits; legal >=2
//  SYNC_STAGES   2   synchroniser flops on rptr; legal >=2
//  AFULL_THRESH  12  walmost_full asserts when level >= this; legal 1..2**ADDRSIZE
// PORTS
//  wclk          in   1           write clock
//  wrst_n        in   1           async active-low reset, write domain
//  rptr          in   ADDRSIZE+1  read pointer, Gray, rclk domain
//  winc          in   1           write request
//  werr_clr      in   1           clears sticky werr
//  waddr         out  ADDRSIZE    memory write address = wbin[ADDRSIZE-1:0]
//  wptr          out  ADDRSIZE+1  write pointer, Gray, registered (to read-side sync)
//  wq_rptr       out  ADDRSIZE+1  synchronised read pointer, Gray
//  wfull         out  1           FIFO full, registered
//  walmost_full  out  1           level >= AFULL_THRESH, registered
//  wlevel        out  ADDRSIZE+1  fill level as seen by write side, 0..2**ADDRSIZE
//  wovf          out  1           1-cycle pulse: winc attempted while wfull
//  werr          out  1           sticky: synchronised rptr changed >1 bit between cycles
// BEHAVIOUR
//  Reset: wrst_n asserted asynchronously, or mid-operation, forces all of the following
//   to 0 immediately: sync chain, wbin, wptr, wq_rptr, wfull, walmost_full, wlevel,
//   wovf, werr, and the prev-sample register.
//   Reset is released synchronously by the integrator.
//  Synchroniser: shift chain s[0] <= rptr, s[k] <= s[k-1]; wq_rptr = s[SYNC_STAGES-1].
//   A stable rptr appears on wq_rptr exactly SYNC_STAGES wclk edges later.
//   No logic between rptr and s[0].
//  rbin: combinational Gray->binary of wq_rptr.
//  Write pointer:
//   - wbin_next = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1), wraps naturally.
//   - wgray_next = (wbin_next>>1) ^ wbin_next.
//   - wbin and wptr are registered from these every edge.
//  Full: wfull <= (wgray_next == {~wq_rptr[A:A-1], wq_rptr[A-2:0]}), where A = ADDRSIZE.
//   - Asserts on the edge that accepts the DEPTH-th outstanding write.
//   - Deasserts SYNC_STAGES+1 edges after a read changes rptr (pessimistic, never optimistic).
//  Level: wlevel <= wbin_next - gray2bin(wq_rptr), modulo 2**(ADDRSIZE+1).
//   - Full gives 2**ADDRSIZE; empty gives 0.
//  Almost full: walmost_full <= (level_next >= AFULL_THRESH), same edge as wlevel.
//   - Must be high whenever wfull is high.
//  Overflow: wovf <= winc & wfull.
//   - The write is dropped; wbin, wptr and the memory address do not move.
//  Gray check:
//   - prev register holds the last wq_rptr.
//   - If popcount(wq_rptr ^ prev) > 1, werr <= 1 (sticky).
//   - werr_clr clears werr; if an error and werr_clr coincide, the error wins.
//   - The check is masked on the first edge after reset.
//  Simultaneous events:
//   - winc on the same edge a read frees space (wq_rptr advancing) is accepted only if
//     wfull was 0 that cycle; no lookahead.
//  Wrap: pointers roll over 2**(A+1)-1 -> 0 with a single Gray bit change; no special casing.
//  All outputs are registered except waddr (slice of wbin) and wq_rptr (last sync flop).
// TESTING
//  1. Reset: hold wrst_n=0 and toggle rptr -> all outputs 0.
//     Release, rptr=5'b00001 -> wq_rptr=00001 after exactly 2 edges (SYNC_STAGES=2).
//  2. Fill: rptr=0, winc=1 for 16 cycles -> wlevel counts 1..16.
//     walmost_full rises at level 12; wfull rises on the edge of write 16; wptr=5'b11000.
//  3. Overflow: from full, winc=1 for 3 cycles -> wovf high 3 cycles; wptr/waddr unchanged; wlevel=16.
//  4. Drain release: from full, rptr 00000->00001 -> wfull drops exactly 3 edges later; wlevel=15.
//  5. Wrap: 40 writes interleaved with reads (ADDRSIZE=4) -> wbin wraps 31->0.
//     wptr changes exactly 1 bit per increment; no false wfull.
//  6. Gray error: rptr 00000->00011 in one step -> werr=1 after 3 edges, stays set.
//     werr_clr=1 -> werr=0 next edge.
//     Repeat with SYNC_STAGES=3 and latency +1.

Source files
------------

// File: rtl/r2w_sync_full.sv
// Write-domain half of the async FIFO: synchronises the read Gray pointer into wclk,
// owns the write pointer and derives full / almost-full / level / overflow / Gray-error status.
module r2w_sync_full #(
  parameter int ADDRSIZE     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                winc,
  input  logic                werr_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wq_rptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf,
  output logic                werr
);
  localparam int A = ADDRSIZE;
  localparam logic [A:0] AF_TH = (A+1)'(AFULL_THRESH);
  localparam logic [A:0] ONE   = (A+1)'(1);

  logic [SYNC_STAGES-1:0][A:0] sync_q;
  logic [A:0] wbin_q, wbin_d, wptr_q, wgray_d;
  logic [A:0] level_q, level_d, rbin, prev_q, gdiff;
  logic       wfull_q, wfull_d, afull_q, afull_d, wovf_q, wovf_d;
  logic       werr_q, werr_d, chk_en_q, inc, gerr;

  // rptr lands directly in the first flop; no logic ahead of the chain
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rptr};

  assign wq_rptr = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= A; i++) rbin[i] = ^(wq_rptr >> i);
  end

  // A write is only accepted against last cycle's registered full; no lookahead
  assign inc     = winc & ~wfull_q;
  assign wbin_d  = wbin_q + {{A{1'b0}}, inc};
  assign wgray_d = (wbin_d >> 1) ^ wbin_d;
  assign wfull_d = (wgray_d == {~wq_rptr[A:A-1], wq_rptr[A-2:0]});
  assign level_d = wbin_d - rbin;
  assign afull_d = (level_d >= AF_TH);
  assign wovf_d  = winc & wfull_q;

  // More than one bit set in the delta means the sampled pointer was not a Gray step
  assign gdiff  = wq_rptr ^ prev_q;
  assign gerr   = chk_en_q & (|(gdiff & (gdiff - ONE)));
  assign werr_d = gerr | (werr_q & ~werr_clr);

  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      level_q  <= '0;
      prev_q   <= '0;
      wfull_q  <= 1'b0;
      afull_q  <= 1'b0;
      wovf_q   <= 1'b0;
      werr_q   <= 1'b0;
      chk_en_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      level_q  <= level_d;
      prev_q   <= wq_rptr;
      wfull_q  <= wfull_d;
      afull_q  <= afull_d;
      wovf_q   <= wovf_d;
      werr_q   <= werr_d;
      chk_en_q <= 1'b1;
    end

  assign waddr        = wbin_q[A-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = afull_q;
  assign wlevel       = level_q;
  assign wovf         = wovf_q;
  assign werr         = werr_q;
endmodule
